// File: rtl/axil_master_arbiter_if.sv
// ============================================================================
// Module      : axil_master_arbiter_if
// Description : Requester command/response and AXI-Lite master bundle for
//               the two-requester AXI-Lite arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface axil_master_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  rq0_valid;
    logic                  rq0_ready;
    logic                  rq0_write;
    logic [ADDR_WIDTH-1:0] rq0_addr;
    logic [DATA_WIDTH-1:0] rq0_wdata;
    logic [STRB_WIDTH-1:0] rq0_wstrb;
    logic                  rq1_valid;
    logic                  rq1_ready;
    logic                  rq1_write;
    logic [ADDR_WIDTH-1:0] rq1_addr;
    logic [DATA_WIDTH-1:0] rq1_wdata;
    logic [STRB_WIDTH-1:0] rq1_wstrb;

    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_rdata;
    logic [RESP_WIDTH-1:0] rsp0_resp;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_rdata;
    logic [RESP_WIDTH-1:0] rsp1_resp;

    logic [ADDR_WIDTH-1:0] m3_axi_awaddr;
    logic                  m3_axi_awvalid;
    logic                  m3_axi_awready;
    logic [DATA_WIDTH-1:0] m3_axi_wdata;
    logic [STRB_WIDTH-1:0] m3_axi_wstrb;
    logic                  m3_axi_wvalid;
    logic                  m3_axi_wready;
    logic [RESP_WIDTH-1:0] m3_axi_bresp;
    logic                  m3_axi_bvalid;
    logic                  m3_axi_bready;
    logic [ADDR_WIDTH-1:0] m3_axi_araddr;
    logic                  m3_axi_arvalid;
    logic                  m3_axi_arready;
    logic [DATA_WIDTH-1:0] m3_axi_rdata;
    logic [RESP_WIDTH-1:0] m3_axi_rresp;
    logic                  m3_axi_rvalid;
    logic                  m3_axi_rready;

    // Arbiter side
    modport master (
        input  rq0_valid, rq0_write, rq0_addr, rq0_wdata, rq0_wstrb,
        input  rq1_valid, rq1_write, rq1_addr, rq1_wdata, rq1_wstrb,
        output rq0_ready, rq1_ready,
        output rsp0_valid, rsp0_rdata, rsp0_resp,
        output rsp1_valid, rsp1_rdata, rsp1_resp,
        output m3_axi_awaddr, m3_axi_awvalid, input m3_axi_awready,
        output m3_axi_wdata, m3_axi_wstrb, m3_axi_wvalid, input m3_axi_wready,
        input  m3_axi_bresp, m3_axi_bvalid, output m3_axi_bready,
        output m3_axi_araddr, m3_axi_arvalid, input m3_axi_arready,
        input  m3_axi_rdata, m3_axi_rresp, m3_axi_rvalid, output m3_axi_rready
    );

    // Requester and AXI-Lite slave side
    modport slave (
        output rq0_valid, rq0_write, rq0_addr, rq0_wdata, rq0_wstrb,
        output rq1_valid, rq1_write, rq1_addr, rq1_wdata, rq1_wstrb,
        input  rq0_ready, rq1_ready,
        input  rsp0_valid, rsp0_rdata, rsp0_resp,
        input  rsp1_valid, rsp1_rdata, rsp1_resp,
        input  m3_axi_awaddr, m3_axi_awvalid, output m3_axi_awready,
        input  m3_axi_wdata, m3_axi_wstrb, m3_axi_wvalid, output m3_axi_wready,
        output m3_axi_bresp, m3_axi_bvalid, input m3_axi_bready,
        input  m3_axi_araddr, m3_axi_arvalid, output m3_axi_arready,
        output m3_axi_rdata, m3_axi_rresp, m3_axi_rvalid, input m3_axi_rready
    );
endinterface

`default_nettype wire

// File: rtl/axil_master_arbiter.sv
// ============================================================================
// Module      : axil_master_arbiter
// Description : Round-robin sharing of one AXI-Lite slave between two command
//               requesters, one transaction in flight, 1-cycle result pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axil_master_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
) (
    input  logic                  s3_axi_aclk,
    input  logic                  s3_axi_areset,
    axil_master_arbiter_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WA   = 3'd1,
        ST_WB   = 3'd2,
        ST_AR   = 3'd3,
        ST_RD   = 3'd4,
        ST_RSP  = 3'd5
    } state_t;

    state_t                state_q;
    logic                  prio_q;      // 1: rq1 wins when both request
    logic                  cmd_id_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic [STRB_WIDTH-1:0] cmd_wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  rsp0_valid_q;
    logic                  rsp1_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [RESP_WIDTH-1:0] rsp_resp_q;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_sel_write;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [STRB_WIDTH-1:0] w_sel_wstrb;
    logic                  w_wa_done;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (state_q == ST_IDLE && !s3_axi_areset) begin
            if (!prio_q) begin
                if (bus.rq0_valid)      w_grant0 = 1'b1;
                else if (bus.rq1_valid) w_grant1 = 1'b1;
            end else begin
                if (bus.rq1_valid)      w_grant1 = 1'b1;
                else if (bus.rq0_valid) w_grant0 = 1'b1;
            end
        end
    end

    assign w_sel_write = w_grant1 ? bus.rq1_write : bus.rq0_write;
    assign w_sel_addr  = w_grant1 ? bus.rq1_addr  : bus.rq0_addr;
    assign w_sel_wdata = w_grant1 ? bus.rq1_wdata : bus.rq0_wdata;
    assign w_sel_wstrb = w_grant1 ? bus.rq1_wstrb : bus.rq0_wstrb;

    // Each write channel counts as done once its valid has already dropped or
    // it handshakes this cycle, so either completion order is handled.
    assign w_wa_done = (!awvalid_q || bus.m3_axi_awready) &&
                       (!wvalid_q  || bus.m3_axi_wready);

    always_ff @(posedge s3_axi_aclk) begin
        if (s3_axi_areset) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            cmd_id_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_wstrb_q  <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_resp_q   <= '0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        cmd_id_q    <= w_grant1;
                        prio_q      <= w_grant0;
                        cmd_addr_q  <= w_sel_addr;
                        cmd_wdata_q <= w_sel_wdata;
                        cmd_wstrb_q <= w_sel_wstrb;
                        if (w_sel_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_WA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= ST_AR;
                        end
                    end
                end
                ST_WA: begin
                    if (awvalid_q && bus.m3_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && bus.m3_axi_wready)   wvalid_q  <= 1'b0;
                    if (w_wa_done) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (bus.m3_axi_bvalid) begin
                        bready_q     <= 1'b0;
                        rsp_rdata_q  <= '0;
                        rsp_resp_q   <= bus.m3_axi_bresp;
                        rsp0_valid_q <= ~cmd_id_q;
                        rsp1_valid_q <= cmd_id_q;
                        state_q      <= ST_RSP;
                    end
                end
                ST_AR: begin
                    if (bus.m3_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (bus.m3_axi_rvalid) begin
                        rready_q     <= 1'b0;
                        rsp_rdata_q  <= bus.m3_axi_rdata;
                        rsp_resp_q   <= bus.m3_axi_rresp;
                        rsp0_valid_q <= ~cmd_id_q;
                        rsp1_valid_q <= cmd_id_q;
                        state_q      <= ST_RSP;
                    end
                end
                ST_RSP:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rq0_ready      = w_grant0;
    assign bus.rq1_ready      = w_grant1;
    assign bus.rsp0_valid     = rsp0_valid_q;
    assign bus.rsp1_valid     = rsp1_valid_q;
    assign bus.rsp0_rdata     = rsp_rdata_q;
    assign bus.rsp1_rdata     = rsp_rdata_q;
    assign bus.rsp0_resp      = rsp_resp_q;
    assign bus.rsp1_resp      = rsp_resp_q;
    assign bus.m3_axi_awaddr  = cmd_addr_q;
    assign bus.m3_axi_awvalid = awvalid_q;
    assign bus.m3_axi_wdata   = cmd_wdata_q;
    assign bus.m3_axi_wstrb   = cmd_wstrb_q;
    assign bus.m3_axi_wvalid  = wvalid_q;
    assign bus.m3_axi_bready  = bready_q;
    assign bus.m3_axi_araddr  = cmd_addr_q;
    assign bus.m3_axi_arvalid = arvalid_q;
    assign bus.m3_axi_rready  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_master_arbiter.sv
// ============================================================================
// Module      : tb_axil_master_arbiter
// Description : Self-checking bench for axil_master_arbiter with a
//               transaction-level reference model and a scripted/random slave.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_master_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) bus ();

    axil_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW)) dut (
        .s3_axi_aclk   (clk),
        .s3_axi_areset (rst),
        .bus           (bus)
    );

    int total = 0;
    int bad   = 0;

    // requester command holders
    bit            pend [2];
    bit            pw   [2];
    logic [AW-1:0] pa   [2];
    logic [DW-1:0] pd   [2];
    logic [SW-1:0] ps   [2];
    bit            rq_rand   = 0;
    bit            keep_busy = 0;

    // reference model of the one in-flight transaction
    bit            busy = 0;
    bit            prio = 0;
    int            cur  = 0;
    bit            cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic [SW-1:0] cs;
    bit            aw_done, w_done, ar_done, resp_done;
    logic [DW-1:0] e_rd;
    logic [RW-1:0] e_rs;

    // slave behaviour
    bit            slv_rand  = 0;
    int            aw_wait   = 0;
    int            b_wait    = 0;
    logic [RW-1:0] fix_bresp = '0;
    logic [RW-1:0] fix_rresp = '0;
    logic [DW-1:0] fix_rdata = '0;
    bit            bv = 0, rv = 0;
    logic [RW-1:0] bresp_v = '0, rresp_v = '0;
    logic [DW-1:0] rdata_v = '0;

    int cyc = 0;
    int last_acc = 0;
    int last_rsp = 0;
    int acc_cyc[$];
    int acc_id[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic post(input int n, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] s);
        pend[n] = 1'b1;
        pw[n]   = wr;
        pa[n]   = a;
        pd[n]   = d;
        ps[n]   = s;
    endtask

    task automatic drive();
        if (rq_rand || keep_busy) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && (keep_busy || $urandom_range(0, 2) == 0))
                    post(n, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
            end
        end
        bus.m3_axi_awready = slv_rand ? 1'($urandom) : (aw_wait == 0);
        bus.m3_axi_wready  = slv_rand ? 1'($urandom) : 1'b1;
        bus.m3_axi_arready = slv_rand ? 1'($urandom) : 1'b1;
        if (!bv && busy && cw && aw_done && w_done && !resp_done) begin
            if (slv_rand ? ($urandom_range(0, 1) == 1) : (b_wait == 0)) begin
                bv      = 1'b1;
                bresp_v = slv_rand ? 3'($urandom) : fix_bresp;
            end else if (!slv_rand) begin
                b_wait--;
            end
        end
        if (!rv && busy && !cw && ar_done && !resp_done) begin
            if (slv_rand ? ($urandom_range(0, 1) == 1) : 1'b1) begin
                rv      = 1'b1;
                rresp_v = slv_rand ? 3'($urandom) : fix_rresp;
                rdata_v = slv_rand ? $urandom : fix_rdata;
            end
        end
        bus.m3_axi_bvalid = bv;
        bus.m3_axi_bresp  = bresp_v;
        bus.m3_axi_rvalid = rv;
        bus.m3_axi_rresp  = rresp_v;
        bus.m3_axi_rdata  = rdata_v;
        bus.rq0_valid = pend[0]; bus.rq0_write = pw[0]; bus.rq0_addr = pa[0];
        bus.rq0_wdata = pd[0];   bus.rq0_wstrb = ps[0];
        bus.rq1_valid = pend[1]; bus.rq1_write = pw[1]; bus.rq1_addr = pa[1];
        bus.rq1_wdata = pd[1];   bus.rq1_wstrb = ps[1];
    endtask

    task automatic observe();
        int w;
        bit e_aw, e_w, e_b, e_ar, e_r, e_p0, e_p1;
        w = -1;
        if (!busy && !rst) begin
            if (!prio) w = pend[0] ? 0 : (pend[1] ? 1 : -1);
            else       w = pend[1] ? 1 : (pend[0] ? 0 : -1);
        end
        e_aw = busy && cw && !aw_done;
        e_w  = busy && cw && !w_done;
        e_b  = busy && cw && aw_done && w_done && !resp_done;
        e_ar = busy && !cw && !ar_done;
        e_r  = busy && !cw && ar_done && !resp_done;
        e_p0 = busy && resp_done && cur == 0;
        e_p1 = busy && resp_done && cur == 1;

        check_eq("rq0_ready", bus.rq0_ready, w == 0);
        check_eq("rq1_ready", bus.rq1_ready, w == 1);
        check_eq("awvalid", bus.m3_axi_awvalid, e_aw);
        check_eq("wvalid", bus.m3_axi_wvalid, e_w);
        check_eq("bready", bus.m3_axi_bready, e_b);
        check_eq("arvalid", bus.m3_axi_arvalid, e_ar);
        check_eq("rready", bus.m3_axi_rready, e_r);
        check_eq("rsp0_valid", bus.rsp0_valid, e_p0);
        check_eq("rsp1_valid", bus.rsp1_valid, e_p1);
        if (e_aw) check_eq("awaddr", bus.m3_axi_awaddr, ca);
        if (e_w) begin
            check_eq("wdata", bus.m3_axi_wdata, cd);
            check_eq("wstrb", bus.m3_axi_wstrb, cs);
        end
        if (e_ar) check_eq("araddr", bus.m3_axi_araddr, ca);
        if (e_p0) begin
            check_eq("rsp0_rdata", bus.rsp0_rdata, e_rd);
            check_eq("rsp0_resp", bus.rsp0_resp, e_rs);
        end
        if (e_p1) begin
            check_eq("rsp1_rdata", bus.rsp1_rdata, e_rd);
            check_eq("rsp1_resp", bus.rsp1_resp, e_rs);
        end

        if (e_p0 || e_p1) begin
            busy     = 1'b0;
            last_rsp = cyc;
        end
        if (e_aw && bus.m3_axi_awready) aw_done = 1'b1;
        else if (e_aw && !slv_rand && aw_wait > 0) aw_wait--;
        if (e_w && bus.m3_axi_wready)  w_done  = 1'b1;
        if (e_ar && bus.m3_axi_arready) ar_done = 1'b1;
        if (e_b && bv) begin
            resp_done = 1'b1; e_rd = '0; e_rs = bresp_v; bv = 1'b0;
        end
        if (e_r && rv) begin
            resp_done = 1'b1; e_rd = rdata_v; e_rs = rresp_v; rv = 1'b0;
        end
        if (w >= 0) begin
            busy = 1'b1; cur = w;
            cw = pw[w]; ca = pa[w]; cd = pd[w]; cs = ps[w];
            pend[w] = 1'b0;
            prio = (w == 0);
            aw_done = 0; w_done = 0; ar_done = 0; resp_done = 0;
            last_acc = cyc;
            acc_cyc.push_back(cyc);
            acc_id.push_back(w);
        end
        if (rst) begin
            busy = 0; prio = 0; bv = 0; rv = 0;
            aw_done = 0; w_done = 0; ar_done = 0; resp_done = 0;
        end
        cyc++;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((busy || pend[0] || pend[1]) && n < limit) begin
            step();
            n++;
        end
        check_eq("drain_timeout", {63'd0, busy | pend[0] | pend[1]}, 64'd0);
    endtask

    initial begin
        pend[0] = 0; pend[1] = 0;
        pw[0] = 0; pw[1] = 0; pa[0] = '0; pa[1] = '0;
        pd[0] = '0; pd[1] = '0; ps[0] = '0; ps[1] = '0;
        repeat (3) step();
        rst = 1'b0;
        check_eq("rst_awaddr", bus.m3_axi_awaddr, 0);
        check_eq("rst_wdata", bus.m3_axi_wdata, 0);
        check_eq("rst_rsp0_rdata", bus.rsp0_rdata, 0);
        check_eq("rst_rsp1_resp", bus.rsp1_resp, 0);

        // single write, zero-wait slave
        post(0, 1'b1, 8'h00, 32'd25, 4'hF);
        run_until_idle(40);
        check_eq("t1_latency", last_rsp - last_acc, 3);
        check_eq("t1_rdata", bus.rsp0_rdata, 0);
        check_eq("t1_resp", bus.rsp0_resp, 0);

        // single read
        fix_rdata = 32'hDEADBEEF;
        post(1, 1'b0, 8'h08, 32'd0, 4'h0);
        run_until_idle(40);
        check_eq("t2_latency", last_rsp - last_acc, 3);
        check_eq("t2_rdata", bus.rsp1_rdata, 32'hDEADBEEF);

        // both requesters saturating from reset release
        rst = 1'b1;
        keep_busy = 1'b1;
        repeat (2) step();
        acc_cyc.delete();
        acc_id.delete();
        rst = 1'b0;
        repeat (18) step();
        keep_busy = 1'b0;
        check_eq("t3_count", acc_cyc.size() >= 4, 1);
        if (acc_cyc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check_eq("t3_grant", acc_id[i], i % 2);
                if (i > 0) check_eq("t3_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
            end
        end
        run_until_idle(40);

        // AW delayed three cycles, W immediate
        aw_wait = 3;
        post(0, 1'b1, 8'h04, 32'd34, 4'hF);
        run_until_idle(40);
        check_eq("t4_latency", last_rsp - last_acc, 6);

        // error response codes pass through
        fix_bresp = 3'd2;
        post(0, 1'b1, 8'h0C, 32'h1234, 4'h3);
        run_until_idle(40);
        check_eq("t5_bresp", bus.rsp0_resp, 2);
        fix_rresp = 3'd3;
        post(1, 1'b0, 8'h0C, 32'd0, 4'h0);
        run_until_idle(40);
        check_eq("t5_rresp", bus.rsp1_resp, 3);
        fix_bresp = '0;
        fix_rresp = '0;

        // reset while waiting for B
        b_wait = 100;
        post(0, 1'b1, 8'h10, 32'h55, 4'h1);
        for (int i = 0; i < 10 && !(busy && aw_done && w_done); i++) step();
        step();
        check_eq("t6_in_wb", bus.m3_axi_bready, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        b_wait = 0;
        check_eq("t6_bready", bus.m3_axi_bready, 0);
        repeat (4) step();
        acc_id.delete();
        post(0, 1'b0, 8'h20, 32'd0, 4'h0);
        post(1, 1'b0, 8'h24, 32'd0, 4'h0);
        step();
        check_eq("t6_prio", acc_id.size() > 0 ? acc_id[0] : 9, 0);
        run_until_idle(60);

        // randomized traffic against a randomly stalling slave
        slv_rand = 1'b1;
        rq_rand  = 1'b1;
        repeat (3000) step();
        rq_rand = 1'b0;
        run_until_idle(500);
        slv_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
